// File: rtl/sort_pkt_arbiter.sv
// sort_pkt_arbiter
//   Shares one packet sorter between CHANNELS Avalon-ST requesters. Whole
//   packets are granted round-robin into the sorter sink, and the id of each
//   granted channel is queued in a tag FIFO. The sorter output is passed
//   through to a single downstream port, tagged with the channel that owns the
//   packet currently at the head of the tag FIFO.
//
// Ports
//   clk_i, arstn_i              clock, asynchronous active-low reset
//   snk_{data,sop,eop,valid}_i  per-channel packet sources (channel k data at [k*DWIDTH +: DWIDTH])
//   snk_ready_o                 per-channel ready
//   srt_{data,sop,eop,valid}_o  towards the sorter sink, srt_ready_i back
//   srt_{data,sop,eop,valid}_i  from the sorter source, srt_ready_o back
//   src_{data,sop,eop,valid}_o  downstream port, src_ready_i back
//   src_channel_o               owner channel of the current output packet
//   drop_cnt_o                  saturating count of orphan beats dropped while idle
module sort_pkt_arbiter #(
  parameter int unsigned DWIDTH       = 32,
  parameter int unsigned CHANNELS     = 4,
  parameter int unsigned MAX_INFLIGHT = 4,
  localparam int unsigned CW          = $clog2(CHANNELS)
) (
  input  logic                         clk_i,
  input  logic                         arstn_i,
  input  logic [CHANNELS*DWIDTH-1:0]   snk_data_i,
  input  logic [CHANNELS-1:0]          snk_sop_i,
  input  logic [CHANNELS-1:0]          snk_eop_i,
  input  logic [CHANNELS-1:0]          snk_valid_i,
  output logic [CHANNELS-1:0]          snk_ready_o,
  output logic [DWIDTH-1:0]            srt_data_o,
  output logic                         srt_sop_o,
  output logic                         srt_eop_o,
  output logic                         srt_valid_o,
  input  logic                         srt_ready_i,
  input  logic [DWIDTH-1:0]            srt_data_i,
  input  logic                         srt_sop_i,
  input  logic                         srt_eop_i,
  input  logic                         srt_valid_i,
  output logic                         srt_ready_o,
  output logic [DWIDTH-1:0]            src_data_o,
  output logic                         src_sop_o,
  output logic                         src_eop_o,
  output logic                         src_valid_o,
  output logic [CW-1:0]                src_channel_o,
  input  logic                         src_ready_i,
  output logic [15:0]                  drop_cnt_o
);

  localparam int unsigned PW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int unsigned NW = $clog2(MAX_INFLIGHT + 1);

  typedef enum logic {
    S_IDLE,
    S_FWD
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   grant_q, grant_d;
  logic [CW-1:0]   last_grant_q, last_grant_d;
  logic [15:0]     drop_cnt_q, drop_cnt_d;
  logic            out_en_q;

  logic [CW-1:0]   tag_mem_q [MAX_INFLIGHT];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [NW-1:0]   count_q;

  logic            tag_empty, tag_full;
  logic            push, pop;
  logic [CHANNELS-1:0] drop_vec;
  logic [16:0]     drop_sum;

  assign tag_empty = (count_q == '0);
  assign tag_full  = (count_q == NW'(MAX_INFLIGHT));

  // Sorter sink side: mux the granted channel, valid only while forwarding.
  assign srt_data_o  = snk_data_i[int'(grant_q)*DWIDTH +: DWIDTH];
  assign srt_valid_o = (state_q == S_FWD) && snk_valid_i[grant_q];
  assign srt_sop_o   = srt_valid_o && snk_sop_i[grant_q];
  assign srt_eop_o   = srt_valid_o && snk_eop_i[grant_q];

  // Sorter source side: output only flows while a tag identifies its owner.
  assign src_data_o    = srt_data_i;
  assign src_sop_o     = srt_sop_i;
  assign src_eop_o     = srt_eop_i;
  assign src_valid_o   = srt_valid_i && !tag_empty;
  assign srt_ready_o   = src_ready_i && !tag_empty;
  assign src_channel_o = tag_empty ? '0 : tag_mem_q[rd_ptr_q];
  assign pop           = src_valid_o && src_ready_i && srt_eop_i;

  assign drop_cnt_o = drop_cnt_q;

  always_comb begin
    logic          found;
    logic [CW-1:0] pick;
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    snk_ready_o  = '0;
    drop_vec     = '0;
    push         = 1'b0;
    found        = 1'b0;
    pick         = '0;
    case (state_q)
      S_IDLE: begin
        for (int unsigned i = 1; i <= CHANNELS; i++) begin
          int unsigned idx;
          idx = (int'(last_grant_q) + i) % CHANNELS;
          if (!found && snk_valid_i[idx] && snk_sop_i[idx]) begin
            found = 1'b1;
            pick  = CW'(idx);
          end
        end
        // In IDLE nothing is in flight beyond the FIFO, so a free FIFO slot
        // is exactly the reservation the next packet's push will consume.
        if (found && !tag_full) begin
          grant_d = pick;
          state_d = S_FWD;
        end
        // Orphans are held off for one cycle after reset release.
        for (int unsigned k = 0; k < CHANNELS; k++) begin
          if (out_en_q && snk_valid_i[k] && !snk_sop_i[k]) begin
            drop_vec[k] = 1'b1;
          end
        end
        snk_ready_o = drop_vec;
      end
      S_FWD: begin
        snk_ready_o[grant_q] = srt_ready_i;
        if (srt_valid_o && srt_ready_i && snk_eop_i[grant_q]) begin
          push         = 1'b1;
          last_grant_d = grant_q;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    drop_sum = {1'b0, drop_cnt_q};
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (drop_vec[k]) drop_sum = drop_sum + 17'd1;
    end
    drop_cnt_d = drop_sum[16] ? '1 : drop_sum[15:0];
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      last_grant_q <= CW'(CHANNELS - 1);
      drop_cnt_q   <= '0;
      out_en_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      drop_cnt_q   <= drop_cnt_d;
      out_en_q     <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= (wr_ptr_q == PW'(MAX_INFLIGHT - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PW'(MAX_INFLIGHT - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) tag_mem_q[wr_ptr_q] <= grant_q;
  end

endmodule
